spike_layer_sequencer: RTL and testbench
========================================

Name: spike_layer_sequencer

Overview:
- Time-multiplexes one signed multiply-free accumulate path across NEURON_COUNT virtual spiking neurons that form a layer.
- Accepts one input spike frame (positive/negative spike vectors) per handshake.
- Fetches each weight from an external weight memory, integrates it into per-neuron membrane potentials, and thresholds each potential.
- Emits one output spike frame per input frame; sits between spike source/encoder and the next layer.

Parameters:
- INPUT_COUNT, 4, spike inputs per frame.
- NEURON_COUNT, 4, virtual neurons sequenced.
- WEIGHT_WIDTH, 8, signed weight width.
- SUM_WIDTH, 12, signed accumulator and membrane-potential width.
- POS_THRESHOLD, 10, signed; potential >= this fires a positive spike.
- NEG_THRESHOLD, -10, signed; potential <= this fires a negative spike.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  sequencer can accept a frame.
- pos_spike_in  in  INPUT_COUNT  positive spike vector.
- neg_spike_in  in  INPUT_COUNT  negative spike vector.
- w_addr  out  $clog2(NEURON_COUNT*INPUT_COUNT)  weight address = j*INPUT_COUNT+i.
- w_data  in  WEIGHT_WIDTH  signed weight; registered read, valid the cycle after w_addr.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts frame.
- pos_spike_out  out  NEURON_COUNT  positive spikes, bit j = neuron j.
- neg_spike_out  out  NEURON_COUNT  negative spikes.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset==0 at clk edge), from any state including mid-frame:
  - state=IDLE; all potentials 0; accumulator 0; spike outputs 0.
  - out_valid=0, w_addr=0, busy=0; in_ready=1 in the cycle after reset is released.
- IDLE: in_ready=1. On in_valid&&in_ready, capture both spike vectors, set j=0, i=0, clear accumulator, go to ACCUM.
- ACCUM: one weight address per cycle, w_addr=j*INPUT_COUNT+i, i increments. After i=INPUT_COUNT-1 is issued, go to DRAIN.
- Returning weights (one cycle after issue) apply a contribution selected by bit i:
  - +w_data if pos=1 and neg=0.
  - -w_data if neg=1 and pos=0.
  - 0 if both bits are set or neither is.
- Arithmetic: weights are sign-extended to SUM_WIDTH; every accumulate and potential add saturates to the SUM_WIDTH signed min/max.
- DRAIN: absorbs the last weight; go to UPDATE.
- UPDATE: p = sat(potential[j] + acc), then:
  - p >= POS_THRESHOLD: set pos bit j, potential[j]=0.
  - else p <= NEG_THRESHOLD: set neg bit j, potential[j]=0.
  - else potential[j]=p, no spike.
  - Then clear the accumulator. If j==NEURON_COUNT-1 go to OUTPUT; else j++, i=0, go to ACCUM.
- Latency: INPUT_COUNT+2 cycles per neuron. out_valid first rises NEURON_COUNT*(INPUT_COUNT+2)+1 cycles after the acceptance cycle (25 with defaults).
- OUTPUT:
  - out_valid=1; spike outputs held stable; in_ready=0.
  - On out_ready, go to IDLE, drop out_valid, and clear spike outputs on the following edge.
- in_ready is low in every state except IDLE; no frame is accepted while busy; frames never overlap.
- Spike output vectors are rebuilt each frame (cleared on acceptance); potentials persist across frames.
- w_addr is don't-care outside ACCUM; implementation holds its last value.

Optional Feature:
- Macro SPIKE_LEAK_EN.
- Defined: in UPDATE, before the add, potential[j] is replaced by potential[j] - (potential[j] >>> 2), using an arithmetic shift. The leak toward zero is computed per frame for every neuron and does not change latency.
- Undefined: no leak; potentials integrate losslessly.

Decomposition:
- Package spiking_pkg holds:
  - seq_state_t enum {IDLE, ACCUM, DRAIN, UPDATE, OUTPUT}.
  - LEAK_SHIFT=2 localparam.
  - sat_add function, parameterised by width through the caller's truncation.
- Sub-module spike_accumulator: registered signed accumulator with clear, contribution select (pos/neg/both/none) and saturation.
- The sequencer holds the FSM, counters, potential array and thresholding.

Test Plan:
- Weights neuron0={1,2,3,4} (addr0..3), rest 0; frame pos=1111, neg=0000 -> acc 10, pos_spike_out=0001, neg_spike_out=0000, out_valid at cycle 25 after acceptance, potential0=0.
- Same weights; frame pos=0000, neg=1111 -> acc -10, neg_spike_out=0001, potential0=0.
- Frames pos=0011 repeated four times (leak undefined) -> potential0 3, 6, 9 with no spikes; 4th frame sum 12 -> pos_spike_out=0001, potential0=0.
- Frame pos=1111, neg=1111 -> all contributions cancel, no spikes, potentials unchanged.
- Hold out_ready=0 for 5 cycles in OUTPUT -> out_valid and spike vectors stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
- Assert reset=0 during ACCUM of neuron 2 -> next cycle: IDLE, all outputs 0, potentials 0; after release in_ready=1 and a fresh pos=1111 frame spikes neuron0.

Source files
------------

// File: rtl/spike_layer_sequencer_pkg.sv
// spiking_pkg: sequencer states, leak shift and the saturating add shared by the layer
package spiking_pkg;
    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, UPDATE, OUTPUT} seq_state_t;
    localparam int LEAK_SHIFT = 2;
    // Clamps a+b to a signed range of `width` bits; the caller truncates the result to that width.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int unsigned width);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (width - 1));
        return s > hi ? hi[31:0] : s < lo ? lo[31:0] : s[31:0];
    endfunction
endpackage

// File: rtl/spike_layer_sequencer_if.sv
// spike_layer_sequencer_if: frame handshake, weight-memory port and output spike frame
interface spike_layer_sequencer_if #(
    parameter int INPUT_COUNT = 4,
    parameter int NEURON_COUNT = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(NEURON_COUNT * INPUT_COUNT)
);
    logic in_valid;
    logic in_ready;
    logic [INPUT_COUNT-1:0] pos_spike_in;
    logic [INPUT_COUNT-1:0] neg_spike_in;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WEIGHT_WIDTH-1:0] w_data;
    logic out_valid;
    logic out_ready;
    logic [NEURON_COUNT-1:0] pos_spike_out;
    logic [NEURON_COUNT-1:0] neg_spike_out;
    logic busy;
    modport master (
        output in_valid, pos_spike_in, neg_spike_in, w_data, out_ready,
        input in_ready, w_addr, out_valid, pos_spike_out, neg_spike_out, busy
    );
    modport slave (
        input in_valid, pos_spike_in, neg_spike_in, w_data, out_ready,
        output in_ready, w_addr, out_valid, pos_spike_out, neg_spike_out, busy
    );
endinterface

// File: rtl/spike_layer_sequencer_accumulator.sv
// spike_accumulator: registered saturating accumulator adding +w, -w or 0 per spike pair
module spike_accumulator
    import spiking_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH = 12
) (
    input logic clk,
    input logic reset,
    input logic clear,
    input logic en,
    input logic pos,
    input logic neg,
    input logic signed [WEIGHT_WIDTH-1:0] w_data,
    output logic signed [SUM_WIDTH-1:0] acc
);
    logic signed [SUM_WIDTH-1:0] w_ext;
    logic signed [SUM_WIDTH-1:0] contrib;
    assign w_ext = SUM_WIDTH'(w_data);
    assign contrib = (pos && !neg) ? w_ext : (neg && !pos) ? -w_ext : '0;
    always_ff @(posedge clk) begin
        if (!reset || clear) acc <= '0;
        else if (en) acc <= SUM_WIDTH'(sat_add(32'(acc), 32'(contrib), SUM_WIDTH));
    end
endmodule

// File: rtl/spike_layer_sequencer.sv
// spike_layer_sequencer: time-multiplexed layer of NEURON_COUNT spiking neurons over one accumulate path
// Define SPIKE_LEAK_EN to leak each potential by a quarter toward zero before every update.
module spike_layer_sequencer
    import spiking_pkg::*;
#(
    parameter int INPUT_COUNT = 4,
    parameter int NEURON_COUNT = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH = 12,
    parameter int POS_THRESHOLD = 10,
    parameter int NEG_THRESHOLD = -10
) (
    input logic clk,
    input logic reset,
    spike_layer_sequencer_if.slave bus
);
    localparam int AW = $clog2(NEURON_COUNT * INPUT_COUNT);
    localparam int JW = NEURON_COUNT > 1 ? $clog2(NEURON_COUNT) : 1;
    localparam int IW = INPUT_COUNT > 1 ? $clog2(INPUT_COUNT) : 1;
    seq_state_t state;
    seq_state_t state_d;
    logic [JW-1:0] j;
    logic [IW-1:0] i;
    logic [IW-1:0] i_q;
    logic en_q;
    logic [AW-1:0] addr;
    logic [INPUT_COUNT-1:0] pos_in;
    logic [INPUT_COUNT-1:0] neg_in;
    logic [NEURON_COUNT-1:0] pos_out;
    logic [NEURON_COUNT-1:0] neg_out;
    logic signed [SUM_WIDTH-1:0] pot [NEURON_COUNT];
    logic signed [SUM_WIDTH-1:0] acc;
    logic signed [SUM_WIDTH-1:0] base;
    logic signed [SUM_WIDTH-1:0] p;
    logic accept;
    logic last_i;
    logic last_j;
    logic fire_p;
    logic fire_n;
    assign accept = state == IDLE && bus.in_valid;
    assign last_i = i == IW'(INPUT_COUNT - 1);
    assign last_j = j == JW'(NEURON_COUNT - 1);
    assign bus.in_ready = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.out_valid = state == OUTPUT;
    assign bus.w_addr = addr;
    assign bus.pos_spike_out = pos_out;
    assign bus.neg_spike_out = neg_out;
`ifdef SPIKE_LEAK_EN
    assign base = pot[j] - (pot[j] >>> LEAK_SHIFT);
`else
    assign base = pot[j];
`endif
    assign p = SUM_WIDTH'(sat_add(32'(base), 32'(acc), SUM_WIDTH));
    assign fire_p = int'(p) >= POS_THRESHOLD;
    assign fire_n = !fire_p && int'(p) <= NEG_THRESHOLD;
    // Weights return one cycle after issue, so the bit select and enable lag the address by a cycle.
    spike_accumulator #(.WEIGHT_WIDTH(WEIGHT_WIDTH), .SUM_WIDTH(SUM_WIDTH)) u_acc (
        .clk(clk),
        .reset(reset),
        .clear(accept || state == UPDATE),
        .en(en_q),
        .pos(pos_in[i_q]),
        .neg(neg_in[i_q]),
        .w_data(bus.w_data),
        .acc(acc)
    );
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE: state_d = bus.in_valid ? ACCUM : IDLE;
            ACCUM: state_d = last_i ? DRAIN : ACCUM;
            DRAIN: state_d = UPDATE;
            UPDATE: state_d = last_j ? OUTPUT : ACCUM;
            OUTPUT: state_d = bus.out_ready ? IDLE : OUTPUT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            j <= '0;
            i <= '0;
            i_q <= '0;
            en_q <= 1'b0;
            addr <= '0;
            pos_in <= '0;
            neg_in <= '0;
            pos_out <= '0;
            neg_out <= '0;
            for (int k = 0; k < NEURON_COUNT; k++) pot[k] <= '0;
        end else begin
            en_q <= state == ACCUM;
            i_q <= i;
            if (accept) begin
                pos_in <= bus.pos_spike_in;
                neg_in <= bus.neg_spike_in;
                j <= '0;
                i <= '0;
                addr <= '0;
                pos_out <= '0;
                neg_out <= '0;
            end
            if (state == ACCUM && !last_i) begin
                i <= i + 1'b1;
                addr <= addr + 1'b1;
            end
            // Addresses are j*INPUT_COUNT+i, so the next neuron simply continues the sequence.
            if (state == UPDATE) begin
                pot[j] <= (fire_p || fire_n) ? '0 : p;
                pos_out[j] <= fire_p;
                neg_out[j] <= fire_n;
                if (!last_j) begin
                    j <= j + 1'b1;
                    i <= '0;
                    addr <= addr + 1'b1;
                end
            end
            if (state == OUTPUT && bus.out_ready) begin
                pos_out <= '0;
                neg_out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spike_layer_sequencer.sv
// tb_spike_layer_sequencer: directed and random frames checked against a frame-level reference model
module tb_spike_layer_sequencer;
    localparam int IC = 4;
    localparam int NC = 4;
    localparam int SMAX = 2047;
    localparam int SMIN = -2048;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int pot_m [NC];
    logic signed [7:0] mem [NC*IC];
    spike_layer_sequencer_if bus ();
    spike_layer_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) bus.w_data <= mem[bus.w_addr];
    function automatic int sat(input int x);
        return x > SMAX ? SMAX : x < SMIN ? SMIN : x;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask
    task automatic model_frame(input logic [IC-1:0] p, input logic [IC-1:0] n, output logic [NC-1:0] po, output logic [NC-1:0] no);
        po = '0;
        no = '0;
        for (int jj = 0; jj < NC; jj++) begin
            int acc;
            int v;
            acc = 0;
            for (int ii = 0; ii < IC; ii++) begin
                int w;
                w = int'(mem[jj*IC+ii]);
                acc = sat(acc + ((p[ii] && !n[ii]) ? w : (n[ii] && !p[ii]) ? -w : 0));
            end
            v = pot_m[jj];
`ifdef SPIKE_LEAK_EN
            v = v - (v >>> 2);
`endif
            v = sat(v + acc);
            if (v >= 10) begin
                po[jj] = 1'b1;
                pot_m[jj] = 0;
            end else if (v <= -10) begin
                no[jj] = 1'b1;
                pot_m[jj] = 0;
            end else pot_m[jj] = v;
        end
    endtask
    task automatic check_pots();
        for (int k = 0; k < NC; k++) chk($sformatf("potential%0d", k), 32'(dut.pot[k]), pot_m[k]);
    endtask
    task automatic run_frame(input logic [IC-1:0] p, input logic [IC-1:0] n, input int hold);
        logic [NC-1:0] ep;
        logic [NC-1:0] en;
        int lat;
        model_frame(p, n, ep, en);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.pos_spike_in = p;
        bus.neg_spike_in = n;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 1);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 25);
        chk("pos_spike_out", 32'(bus.pos_spike_out), 32'(ep));
        chk("neg_spike_out", 32'(bus.neg_spike_out), 32'(en));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.pos_spike_in = 4'($urandom);
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 1);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
            chk("hold_pos_out", 32'(bus.pos_spike_out), 32'(ep));
            chk("hold_neg_out", 32'(bus.neg_spike_out), 32'(en));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_pos_out", 32'(bus.pos_spike_out), 0);
        chk("idle_neg_out", 32'(bus.neg_spike_out), 0);
        check_pots();
    endtask
    task automatic load_directed();
        for (int a = 0; a < NC*IC; a++) mem[a] = a < IC ? 8'(a + 1) : 8'sd0;
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.pos_spike_in = '0;
        bus.neg_spike_in = '0;
        for (int k = 0; k < NC; k++) pot_m[k] = 0;
        load_directed();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_w_addr", 32'(bus.w_addr), 0);
        chk("rst_pos_out", 32'(bus.pos_spike_out), 0);
        chk("rst_neg_out", 32'(bus.neg_spike_out), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 1);
        run_frame(4'b1111, 4'b0000, 0);
        run_frame(4'b0000, 4'b1111, 0);
        repeat (4) run_frame(4'b0011, 4'b0000, 0);
        run_frame(4'b0001, 4'b0000, 0);
        run_frame(4'b1111, 4'b1111, 0);
        run_frame(4'b0110, 4'b0000, 5);
        for (int f = 0; f < 20; f++) begin
            for (int a = 0; a < NC*IC; a++) mem[a] = 8'($urandom_range(0, 255));
            run_frame(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end
        for (int f = 0; f < 10; f++) begin
            for (int a = 0; a < NC*IC; a++) mem[a] = 8'(int'($urandom_range(0, 6)) - 3);
            run_frame(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end
        load_directed();
        @(negedge clk);
        bus.pos_spike_in = 4'b1111;
        bus.neg_spike_in = 4'b0000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 1);
        chk("mid_w_addr", 32'(bus.w_addr), 9);
        reset = 1'b0;
        for (int k = 0; k < NC; k++) pot_m[k] = 0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_w_addr", 32'(bus.w_addr), 0);
        chk("midrst_pos_out", 32'(bus.pos_spike_out), 0);
        chk("midrst_neg_out", 32'(bus.neg_spike_out), 0);
        check_pots();
        reset = 1'b1;
        @(negedge clk);
        chk("midrel_in_ready", 32'(bus.in_ready), 1);
        run_frame(4'b1111, 4'b0000, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
